// File: rtl/lap_stash.sv
// rtl/lap_stash.sv - ring history of captured laps with a browsable view pointer
// Define LAP_STASH_WRAP_EN to let browsing wrap between newest and oldest.
module lap_stash #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    input  logic             next_sample,
    input  logic             prev_sample,
    output logic [WIDTH-1:0] sample_out,
    output logic [PTR_W-1:0] vis_age,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] vis_ptr;
    logic [PTR_W-1:0] newest_ptr;
    logic [PTR_W-1:0] oldest_ptr;
    logic [PTR_W-1:0] browse_ptr;
    logic [PTR_W-1:0] age_raw;
    logic [CNT_W-1:0] wr_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_PTR : p - PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Modulo-DEPTH differences: the true result is below DEPTH, so adding DEPTH
    // in the truncated width recovers it on underflow even for non-power-of-2 DEPTH.
    assign wr_cnt     = CNT_W'(wr_ptr);
    assign newest_ptr = ptr_dec(wr_ptr);
    assign oldest_ptr = (wr_cnt >= count) ? PTR_W'(wr_cnt - count)
                                          : PTR_W'(wr_cnt - count + CNT_W'(DEPTH));
    assign age_raw    = (newest_ptr >= vis_ptr) ? newest_ptr - vis_ptr
                                                : newest_ptr - vis_ptr + PTR_W'(DEPTH);

    always_comb begin
        browse_ptr = vis_ptr;
        if (!empty && next_sample && !prev_sample) begin
            if (vis_ptr != newest_ptr) begin
                browse_ptr = ptr_inc(vis_ptr);
            end else begin
`ifdef LAP_STASH_WRAP_EN
                browse_ptr = oldest_ptr;
`else
                browse_ptr = vis_ptr;
`endif
            end
        end else if (!empty && prev_sample && !next_sample) begin
            if (vis_ptr != oldest_ptr) begin
                browse_ptr = ptr_dec(vis_ptr);
            end else begin
`ifdef LAP_STASH_WRAP_EN
                browse_ptr = newest_ptr;
`else
                browse_ptr = vis_ptr;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            vis_ptr <= '0;
            count   <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            vis_ptr <= '0;
            count   <= '0;
        end else if (sample_in_valid) begin
            vis_ptr <= wr_ptr;
            wr_ptr  <= ptr_inc(wr_ptr);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else begin
            vis_ptr <= browse_ptr;
        end
    end

    // Contents are never read while empty, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (sample_in_valid && !clear) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    assign sample_out = empty ? '0 : mem[vis_ptr];
    assign vis_age    = empty ? '0 : age_raw;

endmodule

// File: tb/tb_lap_stash.sv
// tb/tb_lap_stash.sv - scoreboard bench for lap_stash (WIDTH=8, DEPTH=5)
module tb_lap_stash;

    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] sample_in = '0;
    logic       sample_in_valid = 1'b0;
    logic       next_sample = 1'b0;
    logic       prev_sample = 1'b0;
    logic [7:0] sample_out;
    logic [2:0] vis_age;
    logic [2:0] count;
    logic       full;
    logic       empty;

    typedef struct {
        logic [7:0] so;
        logic [2:0] age;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference: list of stored laps (oldest first) and the viewed distance from newest.
    logic [7:0] hist[$];
    int         ref_age = 0;

    lap_stash #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset_n),
        .clear(clear),
        .sample_in(sample_in),
        .sample_in_valid(sample_in_valid),
        .next_sample(next_sample),
        .prev_sample(prev_sample),
        .sample_out(sample_out),
        .vis_age(vis_age),
        .count(count),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        int n;
        n       = hist.size();
        e.so    = (n > 0) ? hist[n - 1 - ref_age] : 8'h00;
        e.age   = 3'(ref_age);
        e.cnt   = 3'(n);
        e.full  = (n == DEPTH);
        e.empty = (n == 0);
        return e;
    endfunction

    task automatic model_step(input logic clr, input logic v, input logic [7:0] d,
                              input logic nx, input logic pv);
        int n;
        if (clr) begin
            hist.delete();
            ref_age = 0;
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            ref_age = 0;
        end else begin
            n = hist.size();
            if (n > 0 && nx && !pv) begin
                if (ref_age > 0) ref_age = ref_age - 1;
`ifdef LAP_STASH_WRAP_EN
                else ref_age = n - 1;
`endif
            end else if (n > 0 && pv && !nx) begin
                if (ref_age < n - 1) ref_age = ref_age + 1;
`ifdef LAP_STASH_WRAP_EN
                else ref_age = 0;
`endif
            end
        end
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input exp_t e);
        expect_val({name, ".sample_out"}, int'(sample_out), int'(e.so));
        expect_val({name, ".vis_age"}, int'(vis_age), int'(e.age));
        expect_val({name, ".count"}, int'(count), int'(e.cnt));
        expect_val({name, ".full"}, int'(full), int'(e.full));
        expect_val({name, ".empty"}, int'(empty), int'(e.empty));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_all("mon", mon_e);
        end
    end

    task automatic step(input logic clr, input logic v, input logic [7:0] d,
                        input logic nx, input logic pv);
        clear           = clr;
        sample_in_valid = v;
        sample_in       = d;
        next_sample     = nx;
        prev_sample     = pv;
        @(posedge clk);
        model_step(clr, v, d, nx, pv);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic nxt();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic prv();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic clr();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all("reset", model_out());
        expect_val("reset.empty_const", int'(empty), 1);
        reset_n = 1'b1;

        wr(8'h11); wr(8'h22); wr(8'h33);
        expect_val("w3.count", int'(count), 3);
        expect_val("w3.out", int'(sample_out), 8'h33);
        expect_val("w3.full", int'(full), 0);
        prv();
        expect_val("p1.out", int'(sample_out), 8'h22);
        prv();
        expect_val("p2.out", int'(sample_out), 8'h11);
        expect_val("p2.age", int'(vis_age), 2);
        prv();
        nxt();
`ifdef LAP_STASH_WRAP_EN
        expect_val("wrap.next_out", int'(sample_out), 8'h11);
`else
        expect_val("sat.next_out", int'(sample_out), 8'h22);
`endif

        clr();
        for (int i = 1; i <= 6; i++) wr(8'(i));
        expect_val("w6.full", int'(full), 1);
        expect_val("w6.count", int'(count), 5);
        expect_val("w6.out", int'(sample_out), 8'h06);
        repeat (4) prv();
        expect_val("p4.out", int'(sample_out), 8'h02);
        expect_val("p4.age", int'(vis_age), 4);
        prv();
`ifdef LAP_STASH_WRAP_EN
        expect_val("wrap.prev_out", int'(sample_out), 8'h06);
`else
        expect_val("sat.prev_out", int'(sample_out), 8'h02);
`endif

        clr();
        wr(8'h0a); wr(8'h0b);
        step(1'b0, 1'b1, 8'h44, 1'b1, 1'b0);
        expect_val("wrnext.out", int'(sample_out), 8'h44);
        expect_val("wrnext.count", int'(count), 3);
        prv();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        expect_val("both.age", int'(vis_age), 1);

        #2 reset_n = 1'b0;
        hist.delete();
        ref_age = 0;
        #1 check_all("async", model_out());
        expect_val("async.count", int'(count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        nxt(); prv();
        expect_val("empty.out", int'(sample_out), 0);
        expect_val("empty.count", int'(count), 0);

        wr(8'h51); wr(8'h52); wr(8'h53); wr(8'h54);
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        expect_val("clrwr.empty", int'(empty), 1);
        expect_val("clrwr.count", int'(count), 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 3),
                 8'($urandom),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 35));
        end

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        expect_val("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
